// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel 3x3 window generator: default pixel width,
// tap width used by the convolution stage, and the window FSM states.
package sobel_pkg;

  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned WIN_W     = 9;

  typedef enum logic {
    S_FILL,
    S_RUN
  } win_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage, addressed by column. The read returns the
// old contents of the addressed entry; the write lands at the clock edge.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = DEF_PIX_W
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  // Contents are deliberately not reset; the fill rows keep stale data out.
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding the Sobel convolution stage.
// Optional feature: define WIN_SOF_SYNC_EN to add the pix_sof frame-resync input.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned PIX_W = DEF_PIX_W
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic [PIX_W-1:0]        pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
`ifdef WIN_SOF_SYNC_EN
  input  logic                    pix_sof,
`endif
  output logic signed [WIN_W-1:0] win_data_1,
  output logic signed [WIN_W-1:0] win_data_2,
  output logic signed [WIN_W-1:0] win_data_3,
  output logic signed [WIN_W-1:0] win_data_4,
  output logic signed [WIN_W-1:0] win_data_5,
  output logic signed [WIN_W-1:0] win_data_6,
  output logic signed [WIN_W-1:0] win_data_7,
  output logic signed [WIN_W-1:0] win_data_8,
  output logic signed [WIN_W-1:0] win_data_9,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic                    frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  win_state_e      state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];

  logic            acc;
  logic            sof_acc;
  logic            qualify;
  logic            last_pix;
  logic [CW-1:0]   lb_addr;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  assign pix_ready = !win_valid_q || win_ready;
  assign acc       = pix_valid && pix_ready;

`ifdef WIN_SOF_SYNC_EN
  assign sof_acc = acc && pix_sof;
`else
  assign sof_acc = 1'b0;
`endif

  // A start-of-frame pixel lands at column 0 regardless of the current count.
  assign lb_addr  = sof_acc ? '0 : col_q;
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign qualify  = (state_q == S_RUN) && (col_q >= CW'(2)) && !sof_acc;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk       (clk),
    .wr_en_i   (acc),
    .addr_i    (lb_addr),
    .wr_data_i (pix_in),
    .rd_data_o (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk       (clk),
    .wr_en_i   (acc),
    .addr_i    (lb_addr),
    .wr_data_i (lb0_rd),
    .rd_data_o (lb1_rd)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q;
    frame_done_d = frame_done_q;
    win_d        = win_q;

    if (acc) begin
      unique case (state_q)
        S_FILL: if (!sof_acc && col_q == COL_LAST && row_q == RW'(1)) state_d = S_RUN;
        S_RUN:  if (sof_acc || last_pix) state_d = S_FILL;
        default: state_d = S_FILL;
      endcase

      if (sof_acc) begin
        col_d = CW'(1);
        row_d = '0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = pix_in;
    end

    // The presented window is either consumed or absent whenever pix_ready is high.
    if (pix_ready) begin
      win_valid_d  = acc && qualify;
      frame_done_d = acc && qualify && last_pix;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_FILL;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  function automatic logic [WIN_W-1:0] to_tap(input logic [PIX_W-1:0] p);
    return {{(WIN_W - PIX_W){1'b0}}, p};
  endfunction

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_data_1 = to_tap(win_q[0][0]);
  assign win_data_2 = to_tap(win_q[0][1]);
  assign win_data_3 = to_tap(win_q[0][2]);
  assign win_data_4 = to_tap(win_q[1][0]);
  assign win_data_5 = to_tap(win_q[1][1]);
  assign win_data_6 = to_tap(win_q[1][2]);
  assign win_data_7 = to_tap(win_q[2][0]);
  assign win_data_8 = to_tap(win_q[2][1]);
  assign win_data_9 = to_tap(win_q[2][2]);

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 4x4 image against a
// window-list reference derived directly from each frame's pixel array.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic              clk = 1'b0;
  logic              rstb;
  logic [7:0]        pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic signed [8:0] wd1, wd2, wd3, wd4, wd5, wd6, wd7, wd8, wd9;
  logic              win_valid;
  logic              win_ready;
  logic              frame_done;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
`ifdef WIN_SOF_SYNC_EN
    .pix_sof    (pix_sof),
`endif
    .win_data_1 (wd1),
    .win_data_2 (wd2),
    .win_data_3 (wd3),
    .win_data_4 (wd4),
    .win_data_5 (wd5),
    .win_data_6 (wd6),
    .win_data_7 (wd7),
    .win_data_8 (wd8),
    .win_data_9 (wd9),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] taps;
    bit          done;
  } exp_t;

  exp_t exp_q[$];
  int   img[W*H];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stall at first window
  int   stall_left = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Windows whose newest pixel falls inside the first n pixels of the frame.
  task automatic queue_windows(input int n);
    exp_t e;
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        if (r * W + c < n) begin
          e.taps = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.taps = (e.taps << 9) | 96'(img[(r - 2 + i) * W + (c - 2 + j)]);
          e.done = (n == W * H) && (r == H - 1) && (c == W - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic send_pix(input int p, input bit sof, input bit gaps);
    bit acc;
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    pix_in    = 8'(p);
    pix_sof   = sof;
    pix_valid = 1'b1;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) chk("accept_timeout", 96'(0), 96'(1));
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit sof_first, input bit gaps);
    for (int i = 0; i < n; i++) send_pix(img[i], sof_first && (i == 0), gaps);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 96'(exp_q.size()), 96'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: win_ready = 1'($urandom_range(0, 1));
      2: if (win_valid && stall_left > 0) begin
           win_ready = 1'b0;
           stall_left--;
         end else begin
           win_ready = 1'b1;
         end
      default: win_ready = 1'b1;
    endcase
  end

  // Protocol-level reference: position in frame decides whether a window
  // appears; the presented taps must match the head of the expected list.
  int pos = 0;
  bit exp_vld = 1'b0;
  always @(negedge clk) begin
    logic [95:0] obs;
    bit acc, sof, qual;
    obs = {15'd0, wd1, wd2, wd3, wd4, wd5, wd6, wd7, wd8, wd9};
    if (!rstb) begin
      chk("rst_taps", obs, 96'(0));
      chk("rst_valid", 96'(win_valid), 96'(0));
      chk("rst_done", 96'(frame_done), 96'(0));
      chk("rst_ready", 96'(pix_ready), 96'(1));
      pos = 0;
      exp_vld = 1'b0;
    end else begin
      chk("win_valid", 96'(win_valid), 96'(exp_vld));
      chk("pix_ready", 96'(pix_ready), 96'(!exp_vld || win_ready));
      if (win_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window", obs, 96'(0));
        end else begin
          chk("taps", obs, exp_q[0].taps);
          chk("frame_done", 96'(frame_done), 96'(exp_q[0].done));
          if (win_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("done_idle", 96'(frame_done), 96'(0));
      end
`ifdef WIN_SOF_SYNC_EN
      sof = pix_sof;
`else
      sof = 1'b0;
`endif
      acc = pix_valid && (!exp_vld || win_ready);
      if (acc) begin
        if (sof) pos = 0;
        qual = (pos / W >= 2) && (pos % W >= 2);
        exp_vld = qual;
        pos = (pos + 1) % (W * H);
      end else begin
        exp_vld = exp_vld && !win_ready;
      end
    end
  end

  initial begin
    rstb = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0; win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;

    // Ramp image, always ready.
    for (int i = 0; i < W * H; i++) img[i] = i;
    queue_windows(W * H);
    send_frame(W * H, 1'b0, 1'b0);
    drain();

    // Downstream stall of 3 cycles on the first window.
    rdy_mode = 2; stall_left = 3;
    queue_windows(W * H);
    send_frame(W * H, 1'b0, 1'b0);
    drain();

    // Random input gaps and random downstream ready.
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) begin
      if (f > 0) for (int i = 0; i < W * H; i++) img[i] = $urandom_range(0, 255);
      queue_windows(W * H);
      send_frame(W * H, 1'b0, 1'b1);
      drain();
    end
    rdy_mode = 0;

    // Back-to-back frames, then a frame with MSB-set pixels and 255 at the end.
    for (int i = 0; i < W * H; i++) img[i] = i;
    queue_windows(W * H);
    send_frame(W * H, 1'b0, 1'b0);
    for (int i = 0; i < W * H; i++) img[i] = 100 + i;
    queue_windows(W * H);
    send_frame(W * H, 1'b0, 1'b0);
    for (int i = 0; i < W * H; i++) img[i] = $urandom_range(128, 254);
    img[W * H - 1] = 255;
    queue_windows(W * H);
    send_frame(W * H, 1'b0, 1'b0);
    drain();

    // Reset mid-frame after 7 pixels, then a full frame.
    for (int i = 0; i < W * H; i++) img[i] = i;
    send_frame(7, 1'b0, 1'b0);
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    queue_windows(W * H);
    send_frame(W * H, 1'b0, 1'b0);
    drain();

`ifdef WIN_SOF_SYNC_EN
    // Aborted 5-pixel frame, then a resynchronised frame.
    send_frame(5, 1'b0, 1'b0);
    for (int i = 0; i < W * H; i++) img[i] = 100 + i;
    queue_windows(W * H);
    send_frame(W * H, 1'b1, 1'b0);
    drain();
    // Abort with a window already presented under random ready.
    rdy_mode = 1;
    for (int i = 0; i < W * H; i++) img[i] = i;
    queue_windows(11);
    send_frame(11, 1'b0, 1'b0);
    for (int i = 0; i < W * H; i++) img[i] = 200 + i;
    queue_windows(W * H);
    send_frame(W * H, 1'b1, 1'b1);
    drain();
    rdy_mode = 0;
`endif

    chk("final_queue", 96'(exp_q.size()), 96'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
